score_counter: RTL and testbench



---
 rtl/score_pkg.sv | 39 +++
 rtl/bcd_digit_add.sv | 26 ++
 rtl/score_counter.sv | 215 +++++++++++++++++++++
 tb/tb_score_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score counter.
//   state_t      - serial-adder FSM states (IDLE, ADD, CHECK)
//   *_PTS        - packed-BCD point values for each scoring source
//   SCORE_MAX    - saturation value of the committed score
//   LIFE_FIRST   - first extra-life threshold (upper BCD byte of the score)
//   LIFE_STEP    - BCD increment of the threshold after each award
//   STREAK_LEN   - diamond events per streak bonus
//   bcd_add_byte - two-digit BCD add returning {carry, sum}
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [23:0] GOLD_PTS    = 24'h000500;
  localparam logic [23:0] DIMOND_PTS  = 24'h000025;
  localparam logic [23:0] MONSTER_PTS = 24'h000250;
  localparam logic [23:0] BONUS_PTS   = 24'h000250;
  localparam logic [23:0] SCORE_MAX   = 24'h999999;
  localparam logic [7:0]  LIFE_STEP   = 8'h02;
  localparam logic [7:0]  LIFE_FIRST  = 8'h02;
  localparam int          STREAK_LEN  = 8;

  // Carry out of the tens digit signals that the byte overflowed past 99.
  function automatic logic [8:0] bcd_add_byte(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] lo;
    logic [4:0] hi;
    logic       c;
    lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    c  = (lo > 5'd9);
    if (c) lo = lo - 5'd10;
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, c};
    if (hi > 5'd9) return {1'b1, 4'(hi - 5'd10), lo[3:0]};
    return {1'b0, hi[3:0], lo[3:0]};
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b  - BCD digit operands (0..9)
//   cin   - carry in from the previous digit
//   s     - BCD sum digit
//   cout  - carry out to the next digit
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      s    = 4'(raw - 5'd10);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/score_counter.sv
// score_counter: accumulates game-event points into a packed-BCD score.
//   clk               - system (pixel) clock
//   resetN            - asynchronous active-low reset
//   game_reset        - synchronous new-game clear, highest priority
//   player_eat_gold   - level input, each rising edge scores 500
//   player_eat_dimond - level input, each rising edge scores 25 and advances the streak
//   monster_killed    - level input, each rising edge scores 250
//   streak_break      - level input, holds the diamond streak at 0
//   score_digits      - committed score, digit 0 in bits [3:0]
//   busy              - high while an addition is in flight
//   extra_life        - one-cycle pulse when a life threshold is crossed
// Events queue in per-source pending counters; one event at a time is added
// digit-serially and the full result is committed atomically in CHECK.
module score_counter
  import score_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int PEND_MAX = 7
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                game_reset,
  input  logic                player_eat_gold,
  input  logic                player_eat_dimond,
  input  logic                monster_killed,
  input  logic                streak_break,
  output logic [4*DIGITS-1:0] score_digits,
  output logic                busy,
  output logic                extra_life
);

  localparam int W           = 4 * DIGITS;
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NSRC        = 4;
  localparam int SRC_GOLD    = 0;
  localparam int SRC_DIMOND  = 1;
  localparam int SRC_MONSTER = 2;
  localparam int SRC_BONUS   = 3;
  localparam logic [2:0] PEND_SAT    = 3'(PEND_MAX);
  localparam logic [2:0] STREAK_LAST = 3'(STREAK_LEN - 1);

  logic [2:0]                ev_prev_reg;
  logic [2:0]                ev_now;
  logic [2:0]                ev_rise;
  logic                      bonus_inc;
  logic [NSRC-1:0]           pend_inc;
  logic [NSRC-1:0]           pend_dec;
  logic [NSRC-1:0][2:0]      pend_cnt;
  logic [NSRC-1:0][W-1:0]    src_pts;
  logic [W-1:0]              sel_pts;
  logic [2:0]                streak_reg;

  state_t                    state_reg, state_next;
  logic [W-1:0]              work_reg, work_next;
  logic [W-1:0]              addend_reg, addend_next;
  logic [W-1:0]              score_reg, score_next;
  logic [W-1:0]              committed;
  logic                      carry_reg, carry_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [7:0]                life_reg, life_next;
  logic                      retired_reg, retired_next;
  logic                      extra_life_reg, extra_life_next;
  logic [3:0]                digit_sum;
  logic                      digit_cout;

  // ---------------- edge detection ----------------
  assign ev_now  = {monster_killed, player_eat_dimond, player_eat_gold};
  assign ev_rise = ev_now & ~ev_prev_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)         ev_prev_reg <= '0;
    else if (game_reset) ev_prev_reg <= '0;
    else                 ev_prev_reg <= ev_now;
  end

  // ---------------- diamond streak ----------------
  // streak_break suppresses the bonus too, even on the 8th diamond.
  assign bonus_inc = ev_rise[1] && !streak_break && (streak_reg == STREAK_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                       streak_reg <= '0;
    else if (game_reset || streak_break) streak_reg <= '0;
    else if (ev_rise[1])               streak_reg <= (streak_reg == STREAK_LAST) ? 3'd0 : streak_reg + 3'd1;
  end

  // ---------------- pending counters ----------------
  assign pend_inc = {bonus_inc, ev_rise[2], ev_rise[1], ev_rise[0]};

  assign src_pts[SRC_GOLD]    = W'(GOLD_PTS);
  assign src_pts[SRC_DIMOND]  = W'(DIMOND_PTS);
  assign src_pts[SRC_MONSTER] = W'(MONSTER_PTS);
  assign src_pts[SRC_BONUS]   = W'(BONUS_PTS);

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
    logic [2:0] cnt_reg;
    // A same-cycle increment and dispatch cancel out.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)         cnt_reg <= '0;
      else if (game_reset) cnt_reg <= '0;
      else if (pend_inc[gi] && !pend_dec[gi]) begin
        if (cnt_reg != PEND_SAT) cnt_reg <= cnt_reg + 3'd1;
      end
      else if (pend_dec[gi] && !pend_inc[gi]) cnt_reg <= cnt_reg - 3'd1;
    end
    assign pend_cnt[gi] = cnt_reg;
  end

  // Fixed-priority dispatch: gold > dimond > monster > bonus.
  always_comb begin
    pend_dec = '0;
    sel_pts  = '0;
    if (state_reg == IDLE) begin
      if      (pend_cnt[SRC_GOLD]    != '0) pend_dec[SRC_GOLD]    = 1'b1;
      else if (pend_cnt[SRC_DIMOND]  != '0) pend_dec[SRC_DIMOND]  = 1'b1;
      else if (pend_cnt[SRC_MONSTER] != '0) pend_dec[SRC_MONSTER] = 1'b1;
      else if (pend_cnt[SRC_BONUS]   != '0) pend_dec[SRC_BONUS]   = 1'b1;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (pend_dec[i]) sel_pts = src_pts[i];
    end
  end

  // ---------------- digit-serial adder ----------------
  // work and addend rotate right one digit per ADD cycle, so the active digit
  // is always [3:0]; after DIGITS rotations both are back in place.
  bcd_digit_add u_digit_add (
    .a    (work_reg[3:0]),
    .b    (addend_reg[3:0]),
    .cin  (carry_reg),
    .s    (digit_sum),
    .cout (digit_cout)
  );

  assign committed = carry_reg ? W'(SCORE_MAX) : work_reg;

  always_comb begin
    state_next      = state_reg;
    work_next       = work_reg;
    addend_next     = addend_reg;
    carry_next      = carry_reg;
    idx_next        = idx_reg;
    score_next      = score_reg;
    life_next       = life_reg;
    retired_next    = retired_reg;
    extra_life_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_dec != '0) begin
          addend_next = sel_pts;
          work_next   = score_reg;
          carry_next  = 1'b0;
          idx_next    = '0;
          state_next  = ADD;
        end
      end
      ADD: begin
        work_next   = {digit_sum, work_reg[W-1:4]};
        addend_next = {addend_reg[3:0], addend_reg[W-1:4]};
        carry_next  = digit_cout;
        if (idx_reg == IDX_W'(DIGITS - 1)) state_next = CHECK;
        else                               idx_next   = idx_reg + 1'b1;
      end
      CHECK: begin
        work_next  = committed;
        score_next = committed;
        // Upper BCD byte compares correctly as unsigned binary.
        if (!retired_reg && (committed[W-1 -: 8] >= life_reg)) begin
          extra_life_next             = 1'b1;
          {retired_next, life_next}   = bcd_add_byte(life_reg, LIFE_STEP);
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      work_reg       <= '0;
      addend_reg     <= '0;
      carry_reg      <= 1'b0;
      idx_reg        <= '0;
      score_reg      <= '0;
      life_reg       <= LIFE_FIRST;
      retired_reg    <= 1'b0;
      extra_life_reg <= 1'b0;
    end else if (game_reset) begin
      state_reg      <= IDLE;
      work_reg       <= '0;
      addend_reg     <= '0;
      carry_reg      <= 1'b0;
      idx_reg        <= '0;
      score_reg      <= '0;
      life_reg       <= LIFE_FIRST;
      retired_reg    <= 1'b0;
      extra_life_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      work_reg       <= work_next;
      addend_reg     <= addend_next;
      carry_reg      <= carry_next;
      idx_reg        <= idx_next;
      score_reg      <= score_next;
      life_reg       <= life_next;
      retired_reg    <= retired_next;
      extra_life_reg <= extra_life_next;
    end
  end

  assign score_digits = score_reg;
  assign busy         = (state_reg != IDLE);
  assign extra_life   = extra_life_reg;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed self-checking bench for score_counter.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
module tb_score_counter;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        game_reset = 1'b0;
  logic        gold = 1'b0;
  logic        dimond = 1'b0;
  logic        monster = 1'b0;
  logic        brk = 1'b0;
  logic [23:0] score_digits;
  logic        busy;
  logic        extra_life;

  int n_vec = 0;
  int n_bad = 0;
  int life_cnt = 0;

  typedef struct {
    string       name;
    logic        g;
    logic        d;
    logic        m;
    logic        b;
    int          reps;
    logic [23:0] exp_score;
    int          exp_lives;
  } vec_t;

  vec_t vecs [15];

  score_counter #(.DIGITS(6), .PEND_MAX(7)) dut (
    .clk               (clk),
    .resetN            (resetN),
    .game_reset        (game_reset),
    .player_eat_gold   (gold),
    .player_eat_dimond (dimond),
    .monster_killed    (monster),
    .streak_break      (brk),
    .score_digits      (score_digits),
    .busy              (busy),
    .extra_life        (extra_life)
  );

  always #5 clk = ~clk;

  // Counts cycles with extra_life high, so a 2-cycle pulse counts twice.
  always @(negedge clk) if (extra_life) life_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_game_reset();
    game_reset = 1'b1;
    cyc(1);
    game_reset = 1'b0;
    cyc(1);
  endtask

  // One-cycle pulse on the selected inputs, then enough idle time for a commit.
  task automatic pulse(input logic g, input logic d, input logic m, input logic b);
    gold = g; dimond = d; monster = m; brk = b;
    cyc(1);
    gold = 1'b0; dimond = 1'b0; monster = 1'b0; brk = 1'b0;
    cyc(9);
  endtask

  task automatic set_vec(input int i, input string nm, input logic g, input logic d,
                         input logic m, input logic b, input int reps,
                         input logic [23:0] exp_score, input int exp_lives);
    vecs[i].name      = nm;
    vecs[i].g         = g;
    vecs[i].d         = d;
    vecs[i].m         = m;
    vecs[i].b         = b;
    vecs[i].reps      = reps;
    vecs[i].exp_score = exp_score;
    vecs[i].exp_lives = exp_lives;
  endtask

  initial begin
    int busy_cnt;
    int life0;

    // Table: cumulative score path from a fresh game up to saturation.
    set_vec(0,  "v_gold",         1, 0, 0, 0, 1,    24'h000500, 0);
    set_vec(1,  "v_dimond",       0, 1, 0, 0, 1,    24'h000525, 0);
    set_vec(2,  "v_monster",      0, 0, 1, 0, 1,    24'h000775, 0);
    set_vec(3,  "v_all_three",    1, 1, 1, 0, 1,    24'h001550, 0);
    set_vec(4,  "v_streak_bonus", 0, 1, 0, 0, 6,    24'h001950, 0);
    set_vec(5,  "v_dimond_brk",   0, 1, 0, 1, 1,    24'h001975, 0);
    set_vec(6,  "v_dimond_x3",    0, 1, 0, 0, 3,    24'h002050, 0);
    set_vec(7,  "v_monster2",     0, 0, 1, 0, 1,    24'h002300, 0);
    set_vec(8,  "v_preload",      1, 0, 0, 0, 35,   24'h019800, 0);
    set_vec(9,  "v_first_life",   1, 0, 0, 0, 1,    24'h020300, 1);
    set_vec(10, "v_no_life",      1, 0, 0, 0, 1,    24'h020800, 0);
    set_vec(11, "v_climb",        1, 0, 0, 0, 1958, 24'h999800, 48);
    set_vec(12, "v_saturate",     1, 0, 0, 0, 1,    24'h999999, 0);
    set_vec(13, "v_sat_dimond",   0, 1, 0, 0, 1,    24'h999999, 0);
    set_vec(14, "v_sat_gold",     1, 0, 0, 0, 1,    24'h999999, 0);

    // ---- reset state ----
    cyc(3);
    check("reset_score", 32'(score_digits), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_extra_life", 32'(extra_life), 32'h0);
    resetN = 1'b1;
    cyc(2);

    // ---- single gold: commit 8 cycles after the sampled edge ----
    gold = 1'b1;
    cyc(1);
    gold = 1'b0;
    busy_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      cyc(1);
      busy_cnt += int'(busy);
    end
    check("gold_before_commit", 32'(score_digits), 32'h0);
    cyc(1);
    busy_cnt += int'(busy);
    check("gold_commit_k8", 32'(score_digits), 32'h000500);
    check("gold_no_life", 32'(extra_life), 32'h0);
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      busy_cnt += int'(busy);
    end
    check("gold_busy_cycles", 32'(busy_cnt), 32'd7);

    // ---- simultaneous events commit in priority order, 8 cycles apart ----
    do_game_reset();
    gold = 1'b1; dimond = 1'b1; monster = 1'b1;
    cyc(1);
    gold = 1'b0; dimond = 1'b0; monster = 1'b0;
    cyc(8);
    check("simul_first", 32'(score_digits), 32'h000500);
    cyc(8);
    check("simul_second", 32'(score_digits), 32'h000525);
    cyc(8);
    check("simul_third", 32'(score_digits), 32'h000775);

    // ---- streak bonus and streak break ----
    do_game_reset();
    repeat (8) pulse(0, 1, 0, 0);
    cyc(20);
    check("streak_8_dimond", 32'(score_digits), 32'h000450);
    do_game_reset();
    repeat (4) pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    repeat (4) pulse(0, 1, 0, 0);
    cyc(20);
    check("streak_broken", 32'(score_digits), 32'h000200);

    // ---- abort in the 3rd ADD cycle clears everything ----
    do_game_reset();
    gold = 1'b1; monster = 1'b1;
    cyc(1);
    gold = 1'b0; monster = 1'b0;
    cyc(3);
    game_reset = 1'b1;
    cyc(1);
    game_reset = 1'b0;
    check("abort_busy_low", 32'(busy), 32'h0);
    check("abort_score", 32'(score_digits), 32'h0);
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(1);
      busy_cnt += int'(busy);
    end
    check("abort_pending_cleared", 32'(busy_cnt), 32'd0);
    check("abort_score_later", 32'(score_digits), 32'h0);

    // ---- held level counts once ----
    do_game_reset();
    gold = 1'b1;
    cyc(20);
    gold = 1'b0;
    cyc(20);
    check("held_gold_once", 32'(score_digits), 32'h000500);

    // ---- pending saturation: 3 gold keep the FSM busy while 10 dimonds pile up ----
    do_game_reset();
    for (int e = 0; e < 10; e++) begin
      dimond = 1'b1;
      gold   = (e < 3);
      cyc(1);
      dimond = 1'b0;
      gold   = 1'b0;
      cyc(1);
    end
    cyc(90);
    check("pend_saturate", 32'(score_digits), 32'h001925);

    // ---- table-driven path to life awards, retirement and saturation ----
    do_game_reset();
    for (int i = 0; i < 15; i++) begin
      life0 = life_cnt;
      repeat (vecs[i].reps) pulse(vecs[i].g, vecs[i].d, vecs[i].m, vecs[i].b);
      cyc(20);
      check({vecs[i].name, "_score"}, 32'(score_digits), 32'(vecs[i].exp_score));
      check({vecs[i].name, "_lives"}, 32'(life_cnt - life0), 32'(vecs[i].exp_lives));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
